// File: rtl/bitserial_weight_feeder_if.sv
// rtl/bitserial_weight_feeder_if.sv - handshake bundle for the bit-serial weight feeder
// Purpose: groups the parallel (activation, weight) input stream and the bit-serial
//          output stream that the feeder presents to the MAC array.
// Signals:
//   in_valid  : input pair valid              in_ready  : feeder can accept a pair
//   prec[1:0] : precision of the offered pair in_act    : activation byte
//   in_wgt    : packed weight byte            out_valid : serial outputs valid
//   out_ready : consumer accepts current bit  w_bit     : current weight bit
//   act_out   : activation of current word    bit_idx   : index of w_bit, 0..7
//   sub_first : LSB of a sub-word             sub_last  : sign bit of a sub-word
//   word_last : last bit of the byte
// Modports: master = environment around the feeder, slave = the feeder itself.
interface bitserial_weight_feeder_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] prec;
   logic [7:0] in_act;
   logic [7:0] in_wgt;
   logic       out_valid;
   logic       out_ready;
   logic       w_bit;
   logic [7:0] act_out;
   logic [2:0] bit_idx;
   logic       sub_first;
   logic       sub_last;
   logic       word_last;

   modport master (
      output in_valid, prec, in_act, in_wgt, out_ready,
      input  in_ready, out_valid, w_bit, act_out, bit_idx, sub_first, sub_last, word_last
   );

   modport slave (
      input  in_valid, prec, in_act, in_wgt, out_ready,
      output in_ready, out_valid, w_bit, act_out, bit_idx, sub_first, sub_last, word_last
   );
endinterface

// File: rtl/bitserial_weight_feeder.sv
// rtl/bitserial_weight_feeder.sv - buffers (act, wgt) pairs and serializes weights LSB-first
// Purpose: transmit side of the bit-serial MAC interface. Pairs are queued in a DEPTH-entry
//          circular FIFO together with their precision; the head word is moved into a shifter
//          and its weight emitted one bit per accepted cycle with the activation held stable.
//          Sub-word markers let the MAC clear its partial sum and negate the sign-bit product.
// Ports:
//   clk      : clock, rising edge
//   rstn     : synchronous active-low reset
//   flush    : synchronous clear of FIFO and shifter (cfg_err is kept)
//   bus      : bitserial_weight_feeder_if.slave (input pair stream + bit-serial output stream)
//   cfg_err  : sticky, a word was accepted with the reserved precision 2'b11
//   word_cnt : (only with BSF_WORD_CNT_EN) count of completed words, wraps at 16 bits
// Optional feature macro: BSF_WORD_CNT_EN
module bitserial_weight_feeder #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     flush,
   bitserial_weight_feeder_if.slave bus,
`ifdef BSF_WORD_CNT_EN
   output logic [15:0]              word_cnt,
`endif
   output logic                     cfg_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [1:0] prec;
      logic [7:0] act;
      logic [7:0] wgt;
   } entry_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          alive_q, alive_d;
   state_t        state_q, state_d;
   logic [7:0]    wgt_q, wgt_d;
   logic [1:0]    prec_q, prec_d;
   logic [7:0]    act_out_q, act_out_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic          out_valid_q, out_valid_d;
   logic          w_bit_q, w_bit_d;
   logic          sub_first_q, sub_first_d;
   logic          sub_last_q, sub_last_d;
   logic          word_last_q, word_last_d;
   logic          cfg_err_q, cfg_err_d;

   logic          in_ready;
   logic          push;
   logic          pop;
   logic          bit_xfer;
   logic          word_done;
   entry_t        head;
   entry_t        in_entry;
   logic [2:0]    sub_mask;
   logic [2:0]    sub_pos;

   always_comb begin
      // in_ready depends only on registered state, so there is no ready-through path.
      // alive_q keeps it low while reset is asserted.
      in_ready       = alive_q && (count_q < FULL);
      push           = bus.in_valid && in_ready && !flush;
      bit_xfer       = (state_q == S_SHIFT) && bus.out_ready;
      word_done      = bit_xfer && (bit_idx_q == 3'd7);
      // Load the head word either from IDLE or directly behind the last bit of the
      // current word, which is what keeps back-to-back words free of bubbles.
      pop            = !flush && (count_q != '0) && ((state_q == S_IDLE) || word_done);
      head           = mem_q[rd_ptr_q];
      in_entry.prec  = bus.prec;
      in_entry.act   = bus.in_act;
      in_entry.wgt   = bus.in_wgt;

      // DEPTH is a power of two, so the pointers wrap naturally.
      wr_ptr_d       = wr_ptr_q + PW'(push);
      rd_ptr_d       = rd_ptr_q + PW'(pop);
      count_d        = count_q + CW'(push) - CW'(pop);
      alive_d        = 1'b1;
      cfg_err_d      = cfg_err_q | (push && (bus.prec == 2'b11));

      state_d        = state_q;
      wgt_d          = wgt_q;
      prec_d         = prec_q;
      act_out_d      = act_out_q;
      bit_idx_d      = bit_idx_q;

      if (pop) begin
         state_d   = S_SHIFT;
         wgt_d     = head.wgt;
         prec_d    = head.prec;
         act_out_d = head.act;
         bit_idx_d = 3'd0;
      end else if (word_done) begin
         state_d   = S_IDLE;
         wgt_d     = '0;
         prec_d    = '0;
         act_out_d = '0;
         bit_idx_d = 3'd0;
      end else if (bit_xfer) begin
         bit_idx_d = bit_idx_q + 3'd1;
      end

      // Flush discards the word in flight and everything buffered; it wins over push/pop.
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         state_d   = S_IDLE;
         wgt_d     = '0;
         prec_d    = '0;
         act_out_d = '0;
         bit_idx_d = 3'd0;
      end

      // Sub-word size minus one; the reserved precision is serialized as 8-bit.
      case (prec_d)
         2'b01:   sub_mask = 3'd3;
         2'b10:   sub_mask = 3'd1;
         default: sub_mask = 3'd7;
      endcase
      sub_pos     = bit_idx_d & sub_mask;

      // Outputs are registered from the next-state values so they line up with bit_idx.
      out_valid_d = (state_d == S_SHIFT);
      w_bit_d     = out_valid_d && wgt_d[bit_idx_d];
      sub_first_d = out_valid_d && (sub_pos == 3'd0);
      sub_last_d  = out_valid_d && (sub_pos == sub_mask);
      word_last_d = out_valid_d && (bit_idx_d == 3'd7);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         alive_q     <= 1'b0;
         state_q     <= S_IDLE;
         wgt_q       <= '0;
         prec_q      <= '0;
         act_out_q   <= '0;
         bit_idx_q   <= 3'd0;
         out_valid_q <= 1'b0;
         w_bit_q     <= 1'b0;
         sub_first_q <= 1'b0;
         sub_last_q  <= 1'b0;
         word_last_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         alive_q     <= alive_d;
         state_q     <= state_d;
         wgt_q       <= wgt_d;
         prec_q      <= prec_d;
         act_out_q   <= act_out_d;
         bit_idx_q   <= bit_idx_d;
         out_valid_q <= out_valid_d;
         w_bit_q     <= w_bit_d;
         sub_first_q <= sub_first_d;
         sub_last_q  <= sub_last_d;
         word_last_q <= word_last_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   // Storage needs no reset: entries are only read once the count says they were written.
   always_ff @(posedge clk) begin
      if (rstn && push) begin
         mem_q[wr_ptr_q] <= in_entry;
      end
   end

`ifdef BSF_WORD_CNT_EN
   logic [15:0] word_cnt_q, word_cnt_d;

   always_comb begin
      word_cnt_d = word_cnt_q + 16'(word_done);
      if (flush) begin
         word_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         word_cnt_q <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
      end
   end

   assign word_cnt = word_cnt_q;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.w_bit     = w_bit_q;
   assign bus.act_out   = act_out_q;
   assign bus.bit_idx   = bit_idx_q;
   assign bus.sub_first = sub_first_q;
   assign bus.sub_last  = sub_last_q;
   assign bus.word_last = word_last_q;
   assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_bitserial_weight_feeder.sv
// tb/tb_bitserial_weight_feeder.sv - self-checking bench for bitserial_weight_feeder
module tb_bitserial_weight_feeder;
   logic clk   = 1'b0;
   logic rstn  = 1'b0;
   logic flush = 1'b0;
   logic cfg_err;
`ifdef BSF_WORD_CNT_EN
   logic [15:0] word_cnt;
`endif

   bitserial_weight_feeder_if bus();

   bitserial_weight_feeder #(.DEPTH(2)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (flush),
      .bus      (bus),
`ifdef BSF_WORD_CNT_EN
      .word_cnt (word_cnt),
`endif
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       w;
      logic [7:0] act;
      logic [2:0] idx;
      logic       sf;
      logic       sl;
      logic       wl;
   } bit_t;

   bit_t exp_q[$];
   logic exp_cfg_err = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Reference: each accepted word becomes eight expected bit records.
   function automatic void model_push(input logic [1:0] p, input logic [7:0] a, input logic [7:0] w);
      int   s;
      bit_t b;
      s = (p == 2'b01) ? 4 : (p == 2'b10) ? 2 : 8;
      for (int i = 0; i < 8; i++) begin
         b.w   = w[i];
         b.act = a;
         b.idx = 3'(i);
         b.sf  = (i % s) == 0;
         b.sl  = (i % s) == (s - 1);
         b.wl  = (i == 7);
         exp_q.push_back(b);
      end
      if (p == 2'b11) exp_cfg_err = 1'b1;
   endfunction

   function automatic bit_t pop_exp();
      bit_t b;
      b = 'x;
      if (exp_q.size() > 0) b = exp_q.pop_front();
      return b;
   endfunction

   // Drive one cycle at the falling edge and report what the next rising edge will transfer.
   task automatic cycle(input logic iv, input logic [1:0] p, input logic [7:0] a, input logic [7:0] w,
                        input logic ordy, input logic fl, input logic rs,
                        output logic ov, output logic xfer, output logic acc, output bit_t obs);
      @(negedge clk);
      bus.in_valid  = iv;
      bus.prec      = p;
      bus.in_act    = a;
      bus.in_wgt    = w;
      bus.out_ready = ordy;
      flush         = fl;
      rstn          = rs;
      #1;
      acc  = iv && bus.in_ready && rs && !fl;
      if (acc) model_push(p, a, w);
      ov   = bus.out_valid;
      xfer = ov && ordy && rs && !fl;
      obs.w   = bus.w_bit;
      obs.act = bus.act_out;
      obs.idx = bus.bit_idx;
      obs.sf  = bus.sub_first;
      obs.sl  = bus.sub_last;
      obs.wl  = bus.word_last;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.prec = 2'b00; bus.in_act = 8'h00; bus.in_wgt = 8'h00;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();
      exp_cfg_err = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] outs;
      rstn = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.prec = 2'b00; bus.in_act = 8'h00; bus.in_wgt = 8'h00;
      repeat (2) @(negedge clk);
      outs = {bus.out_valid, bus.w_bit, bus.act_out, bus.bit_idx, bus.sub_first, bus.sub_last, cfg_err};
      checks++;
      if (outs !== 16'h0000 || bus.word_last !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0000", outs);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
      end
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL release: in_ready %b out_valid %b expected 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_precision(input logic [1:0] p, input logic [7:0] w, input logic [7:0] sf_exp,
                                 input logic [7:0] sl_exp);
      logic ov, xfer, acc;
      bit_t obs, e;
      logic [7:0] a, got_w, got_sf, got_sl;
      int nx, first_v;
      do_reset();
      a = (p == 2'b00) ? 8'h67 : 8'($urandom);
      nx = 0; first_v = -1; got_w = '0; got_sf = '0; got_sl = '0;
      for (int c = 0; c < 20; c++) begin
         cycle(c == 0, p, a, w, 1'b1, 1'b0, 1'b1, ov, xfer, acc, obs);
         if (ov && first_v < 0) first_v = c;
         if (xfer) begin
            e = pop_exp();
            checks++;
            if (obs !== e) begin
               errors++; $display("FAIL prec%0d_bit: got %h expected %h", p, obs, e);
            end
            got_w[obs.idx] = obs.w; got_sf[obs.idx] = obs.sf; got_sl[obs.idx] = obs.sl;
            nx++;
         end
      end
      checks++;
      if (first_v != 2) begin errors++; $display("FAIL prec%0d_latency: got %0d expected 2", p, first_v); end
      checks++;
      if (nx != 8) begin errors++; $display("FAIL prec%0d_count: got %0d expected 8", p, nx); end
      checks++;
      if (got_w !== w) begin errors++; $display("FAIL prec%0d_bits: got %h expected %h", p, got_w, w); end
      checks++;
      if (got_sf !== sf_exp) begin errors++; $display("FAIL prec%0d_sub_first: got %h expected %h", p, got_sf, sf_exp); end
      checks++;
      if (got_sl !== sl_exp) begin errors++; $display("FAIL prec%0d_sub_last: got %h expected %h", p, got_sl, sl_exp); end
   endtask

   task automatic test_back_to_back();
      logic ov, xfer, acc, ended;
      bit_t obs, e;
      logic [7:0] wa[3], ww[3];
      logic [1:0] wp[3];
      int k, run;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wa[i] = 8'($urandom); ww[i] = 8'($urandom); wp[i] = 2'($urandom_range(0, 3));
      end
      k = 0;
      for (int c = 0; c < 6; c++) begin
         if (k < 3) cycle(1'b1, wp[k], wa[k], ww[k], 1'b0, 1'b0, 1'b1, ov, xfer, acc, obs);
         else       cycle(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ov, xfer, acc, obs);
         if (acc) k++;
      end
      checks++;
      if (k != 3) begin errors++; $display("FAIL b2b_accepted: got %0d expected 3", k); end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", bus.in_ready); end
      run = 0; ended = 1'b0;
      for (int c = 0; c < 40; c++) begin
         cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, ov, xfer, acc, obs);
         if (ov && !ended) run++;
         if (!ov && run > 0) ended = 1'b1;
         if (xfer) begin
            e = pop_exp();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL b2b_bit: got %h expected %h", obs, e); end
         end
      end
      checks++;
      if (run != 24) begin errors++; $display("FAIL b2b_contiguous: got %0d expected 24", run); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drained: got %0d expected 0", exp_q.size()); end
      checks++;
      if (cfg_err !== exp_cfg_err) begin errors++; $display("FAIL b2b_cfg_err: got %b expected %b", cfg_err, exp_cfg_err); end
`ifdef BSF_WORD_CNT_EN
      checks++;
      if (word_cnt !== 16'd3) begin errors++; $display("FAIL b2b_word_cnt: got %0d expected 3", word_cnt); end
`endif
   endtask

   task automatic test_stall();
      logic ov, xfer, acc, ordy;
      bit_t obs, e;
      logic [7:0] a, w;
      logic [1:0] p;
      int nx;
      do_reset();
      a = 8'($urandom); w = 8'($urandom); p = 2'($urandom_range(0, 2));
      nx = 0;
      for (int c = 0; c < 25; c++) begin
         ordy = !(c >= 6 && c <= 8);
         cycle(c == 0, p, a, w, ordy, 1'b0, 1'b1, ov, xfer, acc, obs);
         if (!ordy) begin
            checks++;
            if (!ov || obs.idx !== 3'd4 || exp_q.size() == 0 || obs !== exp_q[0]) begin
               errors++; $display("FAIL stall_frozen: got %h idx %0d expected idx 4", obs, obs.idx);
            end
         end
         if (xfer) begin
            e = pop_exp(); nx++;
            checks++;
            if (obs !== e) begin errors++; $display("FAIL stall_bit: got %h expected %h", obs, e); end
         end
      end
      checks++;
      if (nx != 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", nx); end
   endtask

   task automatic test_random();
      logic ov, xfer, acc;
      bit_t obs, e;
      logic [7:0] a, w;
      logic [1:0] p;
      int sent;
      do_reset();
      sent = 0;
      a = 8'($urandom); w = 8'($urandom); p = 2'($urandom_range(0, 3));
      for (int c = 0; c < 3000; c++) begin
         cycle((sent < 40) && ($urandom_range(0, 3) != 0), p, a, w, $urandom_range(0, 3) != 0,
               1'b0, 1'b1, ov, xfer, acc, obs);
         if (acc) begin
            sent++;
            a = 8'($urandom); w = 8'($urandom); p = 2'($urandom_range(0, 3));
         end
         if (xfer) begin
            e = pop_exp();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL random_bit: got %h expected %h", obs, e); end
         end
         if (sent == 40 && exp_q.size() == 0) break;
      end
      checks++;
      if (sent != 40 || exp_q.size() != 0) begin
         errors++; $display("FAIL random_timeout: sent %0d pending %0d expected 40 0", sent, exp_q.size());
      end
      checks++;
      if (cfg_err !== exp_cfg_err) begin errors++; $display("FAIL random_cfg_err: got %b expected %b", cfg_err, exp_cfg_err); end
   endtask

   task automatic test_abort();
      logic ov, xfer, acc, ab, late, exp_c;
      bit_t obs, e;
      logic [7:0] a0, w0, a1, w1;
      do_reset();
      a0 = 8'($urandom); w0 = 8'($urandom);
      for (int c = 0; c < 14; c++) begin
         cycle(c == 0, 2'b11, a0, w0, 1'b1, 1'b0, 1'b1, ov, xfer, acc, obs);
         if (xfer) begin
            e = pop_exp();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL cfg_bit: got %h expected %h", obs, e); end
         end
      end
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set: got %b expected 1", cfg_err); end
      for (int m = 0; m < 2; m++) begin
         a0 = 8'($urandom); w0 = 8'($urandom); a1 = 8'($urandom); w1 = 8'($urandom);
         late = 1'b0;
         exp_c = (m == 0);
         for (int c = 0; c < 20; c++) begin
            ab = (c == 7);
            cycle(c < 2, 2'b00, (c == 0) ? a0 : a1, (c == 0) ? w0 : w1, 1'b1,
                  ab && (m == 0), !(ab && (m == 1)), ov, xfer, acc, obs);
            if (ab) begin
               checks++;
               if (!ov || obs.idx !== 3'd5) begin
                  errors++; $display("FAIL abort%0d_idx: got valid %b idx %0d expected 1 5", m, ov, obs.idx);
               end
               exp_q.delete();
               if (m == 1) exp_cfg_err = 1'b0;
            end else if (c == 8) begin
               checks++;
               if (ov !== 1'b0) begin errors++; $display("FAIL abort%0d_valid: got %b expected 0", m, ov); end
               checks++;
               if (cfg_err !== exp_c) begin errors++; $display("FAIL abort%0d_cfg_err: got %b expected %b", m, cfg_err, exp_c); end
               if (m == 0) begin
                  checks++;
                  if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort0_ready: got %b expected 1", bus.in_ready); end
`ifdef BSF_WORD_CNT_EN
                  checks++;
                  if (word_cnt !== 16'd0) begin errors++; $display("FAIL abort0_word_cnt: got %0d expected 0", word_cnt); end
`endif
               end
            end else if (c > 8) begin
               if (ov) late = 1'b1;
            end else if (xfer) begin
               e = pop_exp();
               checks++;
               if (obs !== e) begin errors++; $display("FAIL abort%0d_bit: got %h expected %h", m, obs, e); end
            end
         end
         checks++;
         if (late !== 1'b0) begin errors++; $display("FAIL abort%0d_resumed: got %b expected 0", m, late); end
      end
   endtask

   initial begin
      test_reset();
      test_precision(2'b00, 8'h0A, 8'h01, 8'h80);
      test_precision(2'b01, 8'h48, 8'h11, 8'h88);
      test_precision(2'b10, 8'h4E, 8'h55, 8'hAA);
      test_back_to_back();
      test_stall();
      test_random();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
